// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width, loader states, opcodes.
// Used by the operand loader, the ALU and the bench.
package alu_pkg;

    localparam int OPBITS = 4;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_DONE = 2'b11
    } ld_state_t;

    localparam logic [OPBITS-1:0] OP_ADD = 4'd0;
    localparam logic [OPBITS-1:0] OP_SUB = 4'd1;
    localparam logic [OPBITS-1:0] OP_AND = 4'd2;
    localparam logic [OPBITS-1:0] OP_OR  = 4'd3;
    localparam logic [OPBITS-1:0] OP_NOT = 4'd4;
    localparam logic [OPBITS-1:0] OP_XOR = 4'd5;
    localparam logic [OPBITS-1:0] OP_SRL = 4'd6;
    localparam logic [OPBITS-1:0] OP_SLL = 4'd7;
    localparam logic [OPBITS-1:0] OP_SRA = 4'd8;
    localparam logic [OPBITS-1:0] OP_SLA = 4'd9;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with history flop; emits a one-cycle
// pulse on each rising edge of the synchronized level.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic s1_q;
    logic s2_q;
    logic hist_q;

    // Flops reset high so a level held through reset gives no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~hist_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand-entry stage: sequences A, B and opcode capture from a
// shared switch bus, one load press per field.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int Nbits  = 5,
    parameter int OPbits = OPBITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [Nbits-1:0]  sw,
    input  logic              load_btn,
    input  logic              clear_btn,
    output logic [Nbits-1:0]  A,
    output logic [Nbits-1:0]  B,
    output logic [OPbits-1:0] ALUop,
    output logic              valid,
    output logic [1:0]        stage
);

    if (Nbits < OPbits) begin : g_width_chk
        $fatal(1, "alu_operand_loader: Nbits must be >= OPbits");
    end

    logic load_p;
    logic clear_p;

    sync_rise u_load_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (load_btn),
        .pulse_o (load_p)
    );

    sync_rise u_clear_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (clear_btn),
        .pulse_o (clear_p)
    );

    ld_state_t         state_q, state_d;
    logic [Nbits-1:0]  a_q, a_d;
    logic [Nbits-1:0]  b_q, b_d;
    logic [OPbits-1:0] op_q, op_d;
    logic              valid_q, valid_d;

    // Next-state and operand capture; clear overrides load.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;
        if (clear_p) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else if (load_p) begin
            unique case (state_q)
                S_A: begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = sw[OPbits-1:0];
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    a_d     = sw;
                    valid_d = 1'b0;
                    state_d = S_B;
                end
                default: state_d = S_A;
            endcase
        end
    end

    // State, operand and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign ALUop = op_q;
    assign valid = valid_q;
    assign stage = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader at Nbits=5 and Nbits=8.
// Expected output tuples are queued per press and popped on change.
module tb_alu_operand_loader;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       v;
        logic [1:0] st;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst5, ld5, cl5;
    logic [4:0] sw5, A5, B5;
    logic [3:0] op5;
    logic       v5;
    logic [1:0] st5;

    logic       rst8, ld8, cl8;
    logic [7:0] sw8, A8, B8;
    logic [3:0] op8;
    logic       v8;
    logic [1:0] st8;

    alu_operand_loader #(.Nbits(5)) dut5 (
        .clk(clk), .rst_n(rst5), .sw(sw5),
        .load_btn(ld5), .clear_btn(cl5),
        .A(A5), .B(B5), .ALUop(op5),
        .valid(v5), .stage(st5)
    );

    alu_operand_loader #(.Nbits(8)) dut8 (
        .clk(clk), .rst_n(rst8), .sw(sw8),
        .load_btn(ld8), .clear_btn(cl8),
        .A(A8), .B(B8), .ALUop(op8),
        .valid(v8), .stage(st8)
    );

    exp_t q5[$];
    exp_t q8[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon = 1'b0;

    logic [22:0] o5, p5, o8, p8;

    task automatic chk(input string nm, input exp_t e,
                       input logic [22:0] obs);
        logic [22:0] ex;
        ex = {e.a, e.b, e.op, e.v, e.st};
        n_cmp++;
        if (obs !== ex || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL %s: got %h at cyc %0d, want %h at cyc %0d",
                     nm, obs, cyc, ex, e.cyc);
        end
    endtask

    // Monitor: every output change must match the next queued entry.
    always @(negedge clk) begin
        exp_t e;
        o5 = {3'b0, A5, 3'b0, B5, op5, v5, st5};
        o8 = {A8, B8, op8, v8, st8};
        if (mon && o5 !== p5) begin
            if (q5.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut5_unexpected: got %h, want no change",
                         o5);
            end else begin
                e = q5.pop_front();
                chk("dut5", e, o5);
            end
        end
        if (mon && o8 !== p8) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut8_unexpected: got %h, want no change",
                         o8);
            end else begin
                e = q8.pop_front();
                chk("dut8", e, o8);
            end
        end
        p5 = o5;
        p8 = o8;
    end

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] op, input logic v,
                                input logic [1:0] st, input int c);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.v = v; e.st = st; e.cyc = c;
        return e;
    endfunction

    task automatic press5(input logic [4:0] s, input logic [7:0] ea,
                          input logic [7:0] eb, input logic [3:0] eop,
                          input logic ev, input logic [1:0] est,
                          input int hold);
        @(negedge clk);
        sw5 = s;
        ld5 = 1'b1;
        q5.push_back(mk(ea, eb, eop, ev, est, cyc + 3));
        repeat (hold) @(negedge clk);
        ld5 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press8(input logic [7:0] s, input logic [7:0] ea,
                          input logic [7:0] eb, input logic [3:0] eop,
                          input logic ev, input logic [1:0] est);
        @(negedge clk);
        sw8 = s;
        ld8 = 1'b1;
        q8.push_back(mk(ea, eb, eop, ev, est, cyc + 3));
        repeat (4) @(negedge clk);
        ld8 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic direct(input string nm, input logic [22:0] obs,
                          input logic [22:0] ex);
        n_cmp++;
        if (obs !== ex) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, obs, ex);
        end
    endtask

    initial begin
        rst5 = 1'b0; ld5 = 1'b0; cl5 = 1'b0; sw5 = '0;
        rst8 = 1'b0; ld8 = 1'b0; cl8 = 1'b0; sw8 = '0;
        repeat (2) @(negedge clk);
        rst5 = 1'b1;
        rst8 = 1'b1;
        @(negedge clk);
        direct("reset5", {3'b0, A5, 3'b0, B5, op5, v5, st5}, 23'h0);
        direct("reset8", {A8, B8, op8, v8, st8}, 23'h0);
        mon = 1'b1;

        // Full entry; bit 4 of the opcode switch is ignored.
        press5(5'b00011, 8'd3, 8'd0, 4'd0, 1'b0, 2'b01, 4);
        press5(5'b00101, 8'd3, 8'd5, 4'd0, 1'b0, 2'b10, 4);
        press5(5'b10111, 8'd3, 8'd5, OP_SLL, 1'b1, 2'b11, 4);

        // Re-entry from S_DONE.
        press5(5'b11111, 8'd31, 8'd5, OP_SLL, 1'b0, 2'b01, 4);

        // Clear and load together in S_B: clear wins.
        @(negedge clk);
        sw5 = 5'd12;
        ld5 = 1'b1;
        cl5 = 1'b1;
        q5.push_back(mk(8'd0, 8'd0, 4'd0, 1'b0, 2'b00, cyc + 3));
        repeat (4) @(negedge clk);
        ld5 = 1'b0;
        cl5 = 1'b0;
        repeat (4) @(negedge clk);

        // Held button for 20 cycles: exactly one load.
        press5(5'd9, 8'd9, 8'd0, 4'd0, 1'b0, 2'b01, 20);
        direct("held_once", {3'b0, A5, 3'b0, B5, op5, v5, st5},
               {8'd9, 8'd0, 4'd0, 1'b0, 2'b01});

        // Advance to S_OP, then reset with load held through release.
        press5(5'd6, 8'd9, 8'd6, 4'd0, 1'b0, 2'b10, 4);
        @(negedge clk);
        sw5 = 5'd2;
        ld5 = 1'b1;
        @(posedge clk);
        #2;
        q5.push_back(mk(8'd0, 8'd0, 4'd0, 1'b0, 2'b00, cyc));
        rst5 = 1'b0;
        #2;
        rst5 = 1'b1;
        repeat (10) @(negedge clk);
        ld5 = 1'b0;
        repeat (4) @(negedge clk);
        press5(5'd2, 8'd2, 8'd0, 4'd0, 1'b0, 2'b01, 4);

        // Nbits=8 full entry; upper opcode bits ignored.
        press8(8'hA5, 8'hA5, 8'h00, 4'd0, 1'b0, 2'b01);
        press8(8'h3C, 8'hA5, 8'h3C, 4'd0, 1'b0, 2'b10);
        press8(8'hF7, 8'hA5, 8'h3C, OP_SLL, 1'b1, 2'b11);

        for (int i = 0; i < 20; i++) begin
            if (q5.size() == 0 && q8.size() == 0) break;
            @(negedge clk);
        end
        while (q5.size() > 0) begin
            exp_t e;
            e = q5.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL dut5_missing: got no change, want cyc %0d",
                     e.cyc);
        end
        while (q8.size() > 0) begin
            exp_t e;
            e = q8.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL dut8_missing: got no change, want cyc %0d",
                     e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Upstream operand-entry stage for the ALU: captures operand A, operand B and a 4-bit opcode from a shared Nbits-wide switch bus, one per button press, and presents them as registered, stable inputs to the ALU. A four-state sequencer cycles through the A, B and opcode entries. A 2-flop synchronizer with rising-edge detect turns each raw button press into exactly one load. `valid` flags a complete operand set for the ALU and its downstream flag/result logic.

## Interface

- `Nbits`, 5, operand width; must be >= `OPbits` (elaboration-time check, fatal otherwise)
- `OPbits`, 4, opcode width (taken from `alu_pkg`)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `sw` in Nbits: switch bus; source for A, B and opcode
- `load_btn` in 1: raw, already-debounced, asynchronous level; each rising edge = one load
- `clear_btn` in 1: raw, already-debounced, asynchronous level; each rising edge = one clear
- `A` out Nbits: registered operand A
- `B` out Nbits: registered operand B
- `ALUop` out OPbits: registered opcode
- `valid` out 1: high while A, B and ALUop form a complete set
- `stage` out 2: current state encoding, drives status LEDs

## Operation

- States, with their `stage` encodings:
  - `S_A` = 2'b00
  - `S_B` = 2'b01
  - `S_OP` = 2'b10
  - `S_DONE` = 2'b11
- `load_p` / `clear_p`: one-cycle pulses from the synchronizer/edge detectors.
- State transitions on `load_p`:
  - `S_A`: A <= `sw`; go to `S_B`.
  - `S_B`: B <= `sw`; go to `S_OP`.
  - `S_OP`: ALUop <= `sw[OPbits-1:0]`; go to `S_DONE`; `valid` <= 1.
  - `S_DONE`: A <= `sw`; B and ALUop keep their old values; `valid` <= 0; go to `S_B`. A press in `S_DONE` therefore starts a new entry.
- On `clear_p`, in any state:
  - A, B and ALUop <= 0.
  - `valid` <= 0.
  - Go to `S_A`.
- `clear_p` and `load_p` in the same cycle: clear wins and the load is dropped.
- With no pulse, every register holds its value. Outputs change only on a pulse cycle.
- `valid` equals (state == `S_DONE`) and is registered, not decoded combinationally from inputs.
- Upper switch bits `sw[Nbits-1:OPbits]` are ignored in `S_OP`.

## Timing

- Reset (asynchronous assert, clock-synchronous effect on release):
  - A, B, ALUop = 0.
  - `valid` = 0; state = `S_A`; `stage` = 2'b00.
  - Synchronizer and history flops = 1, so a button held through reset release generates no pulse.
- Synchronizer path:
  - `load_btn` rising before edge k reaches sync stage 2 after edge k+1.
  - `load_p` is high during cycle k+1 to k+2.
  - The register update is visible after edge k+2. Total latency is 3 rising edges, raw input to output.
- A held button yields exactly one pulse. A new pulse requires the synchronized level to go low for at least 1 cycle, then high.
- Back-to-back presses are each honoured if every low/high phase lasts at least 2 clock cycles.
- Reset asserted mid-entry (e.g., in `S_OP`) discards partial operands immediately; no `valid` is produced.
- `sw` is sampled only in the cycle where `load_p` = 1. It is treated as quasi-static and is not synchronized.

## Structure

- `alu_pkg`:
  - `localparam OPBITS = 4`
  - `typedef enum logic [1:0] {S_A, S_B, S_OP, S_DONE} ld_state_t`
  - ALU opcode constants: `OP_ADD`=0, `OP_SUB`=1, `OP_AND`=2, `OP_OR`=3, `OP_NOT`=4, `OP_XOR`=5, `OP_SRL`=6, `OP_SLL`=7, `OP_SRA`=8, `OP_SLA`=9. These are shared with the ALU and the bench.
- Sub-module `sync_rise`:
  - 2-flop synchronizer plus history flop.
  - Outputs a one-cycle rising-edge pulse.
  - Reset value is 1.
  - Instantiated twice, once for load and once for clear.
- FSM and operand registers sit in one `always_ff` block with asynchronous `rst_n`. Outputs come directly from flops.

## Test plan

- **Full entry:** reset; press load with `sw`=5'b00011, then 5'b00101, then 5'b10111. Expected: A=3, B=5, ALUop=4'b0111; `valid`=1 and `stage`=2'b11, 3 edges after the last press; bit 4 of `sw` ignored.
- **Latency and single pulse:** hold `load_btn` high for 20 cycles. Expected: A updates exactly at edge 3; state stays `S_B`; no second load.
- **Re-entry from `S_DONE`:** after a full entry, press load with `sw`=5'b11111. Expected: A=31, B and ALUop unchanged, `valid`=0, `stage`=2'b01.
- **Clear priority:** raise load and clear on the same cycle while in `S_B`. Expected: all outputs 0, `stage`=2'b00, `valid`=0; B not loaded.
- **Reset mid-operation:** pulse `rst_n` low for less than 1 cycle while in `S_OP`. Expected: asynchronous return to all-zero outputs and `S_A`. With `load_btn` held through release, there is no load until the button is released and pressed again.
- **Parameter sweep:** elaborate with `Nbits`=8 and repeat the full entry with A=8'hA5 and B=8'h3C. Expected: exact capture.
